// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
// Holds the arbiter state encoding, the byte type and a width helper.
package uart_pkg;

   localparam int UartByteW = 8;

   typedef logic [UartByteW-1:0] byte_t;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } uart_arb_state_e;

   // Never returns 0, so a single requester or a tiny count still gets a 1-bit register.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr_i, with wrap.
// Produces the winner as one-hot, as an index, and an any-request flag.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int IdxW   = clog2_min1(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] onehot_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              any_o
);

   logic [IdxW-1:0] cand;

   // NOTE: every output gets a default before the loop so no path leaves a latch behind.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      cand     = '0;
      // Scan from the farthest offset to the nearest; the slot closest to ptr_i is written last and wins.
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = IdxW'((int'(ptr_i) + k) % NumReq);
         if (req_i[cand]) begin
            onehot_o       = '0;
            onehot_o[cand] = 1'b1;
            idx_o          = cand;
            any_o          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one uart_tx among NumReq byte streams.
// Define UART_ARB_TIMEOUT_EN to release a grant whose owner stalls for TimeoutCycles.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NumReq        = 4,
   parameter int DataWidth     = 8,
   parameter int MaxBurst      = 16,
   parameter int TimeoutCycles = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumReq-1:0]              req_valid_i,
   input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
   input  logic [NumReq-1:0]              req_last_i,
   output logic [NumReq-1:0]              req_ready_o,
   output logic                           tx_valid_o,
   output logic [DataWidth-1:0]           tx_data_o,
   input  logic                           tx_ready_i,
   output logic [NumReq-1:0]              grant_o,
   output logic                           active_o,
   output logic                           timeout_o
);

   localparam int IdxW   = clog2_min1(NumReq);
   localparam int BurstW = clog2_min1(MaxBurst + 1);

   localparam logic [0:0] StIdle = ARB_IDLE;
   localparam logic [0:0] StLock = ARB_LOCK;

   localparam logic [BurstW-1:0] BurstLast = BurstW'((MaxBurst == 0) ? 0 : MaxBurst - 1);
   localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumReq - 1);

   logic [0:0]        state_q,     state_d;
   logic [NumReq-1:0] grant_q,     grant_d;
   logic [IdxW-1:0]   gidx_q,      gidx_d;
   logic [IdxW-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;

   logic [NumReq-1:0] pick_onehot;
   logic [IdxW-1:0]   pick_idx;
   logic              pick_any;

   logic lock_en, g_valid, g_last, xfer, burst_hit, timeout, rel;

   uart_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   // Gating with rst_i drops the grant in the same cycle reset is raised.
   assign lock_en   = (state_q == StLock) && !rst_i;
   assign g_valid   = |(req_valid_i & grant_q);
   assign g_last    = |(req_last_i & grant_q);
   assign tx_valid_o = lock_en && g_valid;
   assign tx_data_o = tx_valid_o ? req_data_i[gidx_q] : '0;
   assign req_ready_o = (lock_en && tx_ready_i) ? grant_q : '0;
   assign grant_o   = lock_en ? grant_q : '0;
   assign active_o  = lock_en;
   assign xfer      = tx_valid_o && tx_ready_i;
   assign burst_hit = (MaxBurst != 0) && (burst_cnt_q == BurstLast);
   assign rel       = (xfer && (g_last || burst_hit)) || timeout;
   assign timeout_o = timeout;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int StallW = clog2_min1(TimeoutCycles + 1);
   localparam logic [StallW-1:0] StallLast = StallW'(TimeoutCycles - 1);

   logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
   logic              stall;

   assign stall   = lock_en && !g_valid;
   assign timeout = stall && (stall_cnt_q == StallLast);

   always_comb begin
      stall_cnt_d = '0;
      if (stall && !timeout) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      if (state_q == StIdle) begin
         if (pick_any) begin
            state_d = StLock;
            grant_d = pick_onehot;
            gidx_d  = pick_idx;
         end
      end else if (rel) begin
         state_d     = StIdle;
         grant_d     = '0;
         gidx_d      = '0;
         rr_ptr_d    = (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
         burst_cnt_d = '0;
      end else if (xfer) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NumReq=4, MaxBurst=4, TimeoutCycles=8).
// Covers reset, packet lock, fairness, burst cap, backpressure and stall handling.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [3:0]            req_valid_i;
   logic [3:0][7:0]       req_data_i;
   logic [3:0]            req_last_i;
   logic [3:0]            req_ready_o;
   logic                  tx_valid_o;
   logic [7:0]            tx_data_o;
   logic                  tx_ready_i;
   logic [3:0]            grant_o;
   logic                  active_o;
   logic                  timeout_o;

   int    total = 0;
   int    bad   = 0;
   byte_t sent_q[$];
   byte_t exp_log[17] = '{8'hA5, 8'h5A, 8'hFF, 8'h11, 8'h10, 8'h20, 8'h10, 8'h20,
                          8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h33, 8'hB5, 8'hB6, 8'h3C, 8'h3D};

   uart_tx_arbiter #(
      .NumReq        (4),
      .DataWidth     (8),
      .MaxBurst      (4),
      .TimeoutCycles (8)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .tx_valid_o  (tx_valid_o),
      .tx_data_o   (tx_data_o),
      .tx_ready_i  (tx_ready_i),
      .grant_o     (grant_o),
      .active_o    (active_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Every accepted byte is logged away from the active edge.
   always @(negedge clk_i) begin
      if (tx_valid_o && tx_ready_i) sent_q.push_back(tx_data_o);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 4'b1111;
      req_last_i  = 4'b0000;
      req_data_i  = '0;
      req_data_i[0] = 8'hA5;
      tx_ready_i  = 1'b1;

      // Reset with every requester valid
      tick();
      tick();
      check("rst_grant",   32'(grant_o), 32'h0);
      check("rst_ready",   32'(req_ready_o), 32'h0);
      check("rst_txvalid", 32'(tx_valid_o), 32'h0);
      check("rst_active",  32'(active_o), 32'h0);
      check("rst_timeout", 32'(timeout_o), 32'h0);
      check("rst_txdata",  32'(tx_data_o), 32'h0);
      rst_i = 1'b0;
      tick();
      settle();
      check("first_grant", 32'(grant_o), 32'h1);

      // Single packet A5,5A,FF from req0
      check("pkt_b0", 32'(tx_data_o), 32'hA5);
      check("pkt_rdy", 32'(req_ready_o), 32'h1);
      tick();
      req_data_i[0] = 8'h5A;
      settle();
      check("pkt_b1", 32'(tx_data_o), 32'h5A);
      tick();
      req_data_i[0] = 8'hFF;
      req_last_i[0] = 1'b1;
      settle();
      check("pkt_b2", 32'(tx_data_o), 32'hFF);
      tick();
      settle();
      check("pkt_rel_grant",  32'(grant_o), 32'h0);
      check("pkt_rel_active", 32'(active_o), 32'h0);
      check("pkt_idle_txd",   32'(tx_data_o), 32'h0);
      req_data_i[1] = 8'h11;
      req_last_i[1] = 1'b1;
      tick();
      settle();
      check("next_from_req1", 32'(grant_o), 32'h2);
      check("req1_data", 32'(tx_data_o), 32'h11);
      tick();
      req_valid_i = 4'b0000;
      settle();
      check("req1_rel", 32'(grant_o), 32'h0);

      // Fairness from rr_ptr=0 with req0 and req2 sending 1-byte packets
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      req_valid_i   = 4'b0101;
      req_last_i    = 4'b0101;
      req_data_i[0] = 8'h10;
      req_data_i[2] = 8'h20;
      for (int r = 0; r < 2; r++) begin
         tick();
         settle();
         check("fair_g0", 32'(grant_o), 32'h1);
         check("fair_r0", 32'(req_ready_o), 32'h1);
         check("fair_d0", 32'(tx_data_o), 32'h10);
         tick();
         settle();
         check("fair_gap0", 32'(grant_o), 32'h0);
         tick();
         settle();
         check("fair_g2", 32'(grant_o), 32'h4);
         check("fair_r2", 32'(req_ready_o), 32'h4);
         check("fair_d2", 32'(tx_data_o), 32'h20);
         tick();
         if (r == 1) req_valid_i = 4'b0000;
         settle();
         check("fair_gap2", 32'(grant_o), 32'h0);
      end

      // Burst cap: req1 streams without last, req3 waits
      req_valid_i   = 4'b0010;
      req_last_i    = 4'b0000;
      req_data_i[1] = 8'hB1;
      tick();
      req_valid_i   = 4'b1010;
      req_data_i[3] = 8'h33;
      req_last_i[3] = 1'b1;
      settle();
      check("burst_grant1", 32'(grant_o), 32'h2);
      for (int b = 1; b <= 4; b++) begin
         req_data_i[1] = 8'(8'hB0 + b);
         settle();
         check("burst_byte", 32'(tx_data_o), 32'(8'hB0 + b));
         tick();
      end
      req_data_i[1] = 8'hB5;
      settle();
      check("burst_cap_rel", 32'(grant_o), 32'h0);
      tick();
      settle();
      check("burst_req3", 32'(grant_o), 32'h8);
      check("burst_req3_d", 32'(tx_data_o), 32'h33);
      tick();
      settle();
      check("burst_req3_rel", 32'(grant_o), 32'h0);
      tick();
      req_valid_i = 4'b0010;
      settle();
      check("burst_resume_g", 32'(grant_o), 32'h2);
      check("burst_resume_d", 32'(tx_data_o), 32'hB5);
      tick();
      req_data_i[1] = 8'hB6;
      tick();

      // Backpressure mid-packet on 3C
      req_data_i[1] = 8'h3C;
      tx_ready_i    = 1'b0;
      settle();
      check("bp_ready", 32'(req_ready_o), 32'h0);
      check("bp_valid", 32'(tx_valid_o), 32'h1);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_hold_g", 32'(grant_o), 32'h2);
         check("bp_hold_d", 32'(tx_data_o), 32'h3C);
         check("bp_hold_r", 32'(req_ready_o), 32'h0);
      end
      tx_ready_i = 1'b1;
      settle();
      check("bp_go_ready", 32'(req_ready_o), 32'h2);
      tick();
      req_data_i[1] = 8'h3D;
      req_last_i[1] = 1'b1;
      settle();
      check("bp_last_d", 32'(tx_data_o), 32'h3D);
      tick();
      req_valid_i = 4'b0000;
      settle();
      check("bp_rel", 32'(grant_o), 32'h0);

      // Stall of granted req2
      req_valid_i   = 4'b0100;
      req_last_i    = 4'b0000;
      req_data_i[2] = 8'hC2;
      tick();
      req_valid_i = 4'b0000;
      settle();
      check("stall_grant", 32'(grant_o), 32'h4);
`ifdef UART_ARB_TIMEOUT_EN
      for (int s = 1; s <= 7; s++) begin
         check("stall_no_to", 32'(timeout_o), 32'h0);
         tick();
      end
      check("to_pulse", 32'(timeout_o), 32'h1);
      check("to_grant_held", 32'(grant_o), 32'h4);
      tick();
      check("to_rel_grant", 32'(grant_o), 32'h0);
      check("to_pulse_end", 32'(timeout_o), 32'h0);
      req_valid_i = 4'b1001;
      tick();
      check("to_rr_ptr3", 32'(grant_o), 32'h8);
`else
      for (int s = 0; s < 12; s++) begin
         repeat (10) tick();
         check("hold_grant",   32'(grant_o), 32'h4);
         check("hold_timeout", 32'(timeout_o), 32'h0);
      end
`endif

      // Reset during LOCK removes the grant at once
      rst_i = 1'b1;
      settle();
      check("rst_lock_grant",  32'(grant_o), 32'h0);
      check("rst_lock_active", 32'(active_o), 32'h0);
      check("rst_lock_valid",  32'(tx_valid_o), 32'h0);
      tick();
      req_valid_i = 4'b0000;
      rst_i = 1'b0;
      tick();

      // Every accepted byte, in order, exactly once
      check("log_len", 32'(sent_q.size()), 32'd17);
      for (int i = 0; i < 17; i++) begin
         if (i < sent_q.size()) check("log_byte", 32'(sent_q[i]), 32'(exp_log[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
